// File: rtl/nv_asyncfifo_rd_cg_ctrl.sv
// Read-side clock-gate sequencer for an async FIFO: OFF -> WAKE -> ON -> HOLD -> OFF.
// Optional statistics counters are enabled by defining NV_ASYNCFIFO_RD_CG_STATS_EN.
module nv_asyncfifo_rd_cg_ctrl #(
  parameter int HOLD_W   = 4,
  parameter int WAKE_CYC = 2
) (
  input  logic              rd_clk,
  input  logic              rd_reset,
  input  logic              fifo_not_empty,
  input  logic              rd_req,
  input  logic              wr_active_sync,
  input  logic              cfg_cg_disable,
  input  logic [HOLD_W-1:0] cfg_idle_hold,
  input  logic              dft_enable_r,
  output logic              rd_clk_en,
  output logic              rd_pop_ok,
  output logic [1:0]        rd_cg_state,
  output logic              rd_idle
`ifdef NV_ASYNCFIFO_RD_CG_STATS_EN
  ,
  output logic [31:0]       stat_gated_cyc,
  output logic [15:0]       stat_wake_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [2:0]        WAKE_LOAD = 3'(WAKE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [2:0]        wake_cnt_q, wake_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              func_en_q;
  logic              idle_q;
  logic              wake;

  assign wake = fifo_not_empty | rd_req | wr_active_sync | cfg_cg_disable;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_OFF: begin
        if (wake) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          wake_cnt_d = wake_cnt_q - 3'd1;
        end
      end
      ST_ON: begin
        if (!wake) begin
          if (cfg_idle_hold == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = cfg_idle_hold;
          end
        end
      end
      ST_HOLD: begin
        // Gate is still open here, so a returning wake skips the WAKE settle period.
        if (wake) begin
          state_d    = ST_ON;
          hold_cnt_d = '0;
        end else if (hold_cnt_q <= HOLD_ONE) begin
          state_d    = ST_OFF;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state_q    <= ST_OFF;
      wake_cnt_q <= '0;
      hold_cnt_q <= '0;
      func_en_q  <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      func_en_q  <= (state_d != ST_OFF);
      idle_q     <= (state_d == ST_OFF);
    end
  end

  // DFT enable is a pure mask on the outputs and never feeds back into the FSM.
  assign rd_clk_en   = func_en_q & dft_enable_r;
  assign rd_pop_ok   = (state_q == ST_ON) & fifo_not_empty & dft_enable_r;
  assign rd_cg_state = state_q;
  assign rd_idle     = idle_q;

`ifdef NV_ASYNCFIFO_RD_CG_STATS_EN
  logic [31:0] gated_cyc_q;
  logic [15:0] wake_cnt_stat_q;

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      gated_cyc_q     <= '0;
      wake_cnt_stat_q <= '0;
    end else begin
      if ((state_q == ST_OFF) && (gated_cyc_q != '1)) begin
        gated_cyc_q <= gated_cyc_q + 32'd1;
      end
      if ((state_q == ST_OFF) && (state_d == ST_WAKE) && (wake_cnt_stat_q != '1)) begin
        wake_cnt_stat_q <= wake_cnt_stat_q + 16'd1;
      end
    end
  end

  assign stat_gated_cyc = gated_cyc_q;
  assign stat_wake_cnt  = wake_cnt_stat_q;
`endif

endmodule

// File: tb/tb_nv_asyncfifo_rd_cg_ctrl.sv
// Self-checking bench for nv_asyncfifo_rd_cg_ctrl: directed scenarios plus randomized
// traffic compared against a deadline-based reference model.
module tb_nv_asyncfifo_rd_cg_ctrl;
  localparam int HOLD_W   = 4;
  localparam int WAKE_CYC = 2;

  logic              clk = 1'b0;
  logic              rd_reset;
  logic              fifo_not_empty;
  logic              rd_req;
  logic              wr_active_sync;
  logic              cfg_cg_disable;
  logic [HOLD_W-1:0] cfg_idle_hold;
  logic              dft_enable_r;
  logic              rd_clk_en;
  logic              rd_pop_ok;
  logic [1:0]        rd_cg_state;
  logic              rd_idle;

  int checks = 0;
  int errors = 0;

  // Reference model: mode plus absolute edge numbers at which timed transitions fall due.
  int     m_mode = 0;
  longint edge_n = 0;
  longint on_at  = 0;
  longint off_at = 0;
  bit     model_ok = 1'b0;

  nv_asyncfifo_rd_cg_ctrl #(.HOLD_W(HOLD_W), .WAKE_CYC(WAKE_CYC)) dut (
    .rd_clk         (clk),
    .rd_reset       (rd_reset),
    .fifo_not_empty (fifo_not_empty),
    .rd_req         (rd_req),
    .wr_active_sync (wr_active_sync),
    .cfg_cg_disable (cfg_cg_disable),
    .cfg_idle_hold  (cfg_idle_hold),
    .dft_enable_r   (dft_enable_r),
    .rd_clk_en      (rd_clk_en),
    .rd_pop_ok      (rd_pop_ok),
    .rd_cg_state    (rd_cg_state),
    .rd_idle        (rd_idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_step();
    bit wake;
    edge_n++;
    wake = fifo_not_empty | rd_req | wr_active_sync | cfg_cg_disable;
    if (rd_reset) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (wake) begin m_mode = 1; on_at = edge_n + WAKE_CYC; end
        1: if (edge_n == on_at) m_mode = 2;
        2: if (!wake) begin
             if (cfg_idle_hold == 0) m_mode = 0;
             else begin m_mode = 3; off_at = edge_n + longint'(cfg_idle_hold); end
           end
        3: if (wake) m_mode = 2;
           else if (edge_n == off_at) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    model_ok = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (model_ok) begin
      check_eq("state", int'(rd_cg_state), m_mode);
      check_eq("clk_en", int'(rd_clk_en), int'((m_mode != 0) && dft_enable_r));
      check_eq("idle", int'(rd_idle), int'(m_mode == 0));
      check_eq("pop_ok", int'(rd_pop_ok), int'((m_mode == 2) && fifo_not_empty && dft_enable_r));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    fifo_not_empty = 1'b0;
    rd_req         = 1'b0;
    wr_active_sync = 1'b0;
    cfg_cg_disable = 1'b0;
  endtask

  initial begin
    rd_reset      = 1'b1;
    cfg_idle_hold = 4'd3;
    dft_enable_r  = 1'b1;
    set_idle();
    repeat (2) cycle();
    check_eq("rst_state", int'(rd_cg_state), 0);
    check_eq("rst_clk_en", int'(rd_clk_en), 0);
    check_eq("rst_idle", int'(rd_idle), 1);
    rd_reset = 1'b0;

    // Idle for 20 cycles: gate must stay closed.
    repeat (20) cycle();
    check_eq("idle20_state", int'(rd_cg_state), 0);

    // Wake latency: enable one cycle after wake, pops WAKE_CYC cycles later.
    fifo_not_empty = 1'b1;
    cycle();
    check_eq("lat_en", int'(rd_clk_en), 1);
    check_eq("lat_pop0", int'(rd_pop_ok), 0);
    cycle();
    check_eq("lat_pop1", int'(rd_pop_ok), 0);
    cycle();
    check_eq("lat_pop2", int'(rd_pop_ok), 1);
    check_eq("lat_on", int'(rd_cg_state), 2);

    // Hysteresis of 3: three HOLD cycles, then OFF.
    fifo_not_empty = 1'b0;
    cycle();
    check_eq("hold1", int'(rd_cg_state), 3);
    cycle();
    check_eq("hold2", int'(rd_cg_state), 3);
    cycle();
    check_eq("hold3", int'(rd_cg_state), 3);
    cycle();
    check_eq("hold_off", int'(rd_cg_state), 0);

    // Re-wake inside HOLD returns straight to ON.
    rd_req = 1'b1;
    repeat (4) cycle();
    rd_req = 1'b0;
    cycle();
    cycle();
    check_eq("rehold", int'(rd_cg_state), 3);
    wr_active_sync = 1'b1;
    cycle();
    check_eq("rewake_on", int'(rd_cg_state), 2);
    wr_active_sync = 1'b0;
    cfg_idle_hold = 4'd0;
    cycle();
    check_eq("hold0_off", int'(rd_cg_state), 0);

    // Forced-open gate: stays ON without pops.
    cfg_cg_disable = 1'b1;
    repeat (100) cycle();
    check_eq("cgdis_on", int'(rd_cg_state), 2);
    check_eq("cgdis_pop", int'(rd_pop_ok), 0);

    // DFT mask while ON.
    fifo_not_empty = 1'b1;
    dft_enable_r = 1'b0;
    repeat (3) cycle();
    check_eq("dft_en", int'(rd_clk_en), 0);
    check_eq("dft_pop", int'(rd_pop_ok), 0);
    check_eq("dft_state", int'(rd_cg_state), 2);
    dft_enable_r = 1'b1;
    #1;
    check_eq("dft_rest_en", int'(rd_clk_en), 1);
    check_eq("dft_rest_pop", int'(rd_pop_ok), 1);

    // Reset in HOLD with a long hold count.
    cfg_cg_disable = 1'b0;
    fifo_not_empty = 1'b0;
    cfg_idle_hold = 4'd7;
    cycle();
    cycle();
    check_eq("pre_rst_hold", int'(rd_cg_state), 3);
    rd_reset = 1'b1;
    cycle();
    check_eq("mid_rst_state", int'(rd_cg_state), 0);
    check_eq("mid_rst_en", int'(rd_clk_en), 0);
    check_eq("mid_rst_idle", int'(rd_idle), 1);
    rd_reset = 1'b0;

    // Randomized traffic in busy/quiet bursts.
    for (int burst = 0; burst < 120; burst++) begin
      int len;
      bit busy;
      len  = int'($urandom_range(1, 25));
      busy = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        fifo_not_empty = busy && ($urandom_range(0, 3) != 0);
        rd_req         = busy && ($urandom_range(0, 2) == 0);
        wr_active_sync = ($urandom_range(0, 15) == 0);
        cfg_cg_disable = ($urandom_range(0, 60) == 0);
        cfg_idle_hold  = HOLD_W'($urandom_range(0, 6));
        dft_enable_r   = ($urandom_range(0, 9) != 0);
        rd_reset       = ($urandom_range(0, 80) == 0);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
